uart8: RTL and testbench

Full-duplex 8N1 UART: an independent receiver and transmitter sharing one clock, with baud timing derived from parameters. It sits between a board-level serial pin pair and byte-wide logic. The byte-side handshake is a one-cycle done pulse plus a busy level. The receiver oversamples 16x and rejects glitched start bits. The transmitter runs at exactly one bit per baud period.

---
 rtl/uart8.sv | 187 ++++++++++++++++++
 tb/tb_uart8.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart8.sv
// Full-duplex 8N1 UART. The receiver oversamples 16x behind a 2-flop synchronizer; the
// transmitter holds each bit for CLOCK_RATE/BAUD_RATE clocks.
module uart8 #(
  parameter int unsigned CLOCK_RATE = 100000000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxEn,
  input  logic       rx,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] out,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in,
  output logic       txBusy,
  output logic       txDone,
  output logic       tx
);

  localparam int unsigned RxDiv  = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int unsigned TxDiv  = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned RxDivW = $clog2(RxDiv + 1);
  localparam int unsigned TxDivW = $clog2(TxDiv + 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Receiver
  state_e              rx_state_q;
  logic                rx_s1_q, rx_s2_q, rx_prev_q;
  logic [RxDivW-1:0]   rx_div_q;
  logic [3:0]          rx_tick_q;
  logic [2:0]          rx_bit_q;
  logic [7:0]          rx_shift_q;
  logic [7:0]          out_q;
  logic                rx_done_q, rx_err_q;
  logic                rx_tick, rx_fall;

  assign rx_tick = (rx_div_q == RxDivW'(RxDiv - 1));
  assign rx_fall = rx_prev_q & ~rx_s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= StIdle;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_div_q   <= '0;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      out_q      <= '0;
      rx_done_q  <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_done_q <= 1'b0;
      rx_err_q  <= 1'b0;
      rx_div_q  <= (rx_state_q == StIdle || rx_tick) ? '0 : rx_div_q + 1'b1;
      if (rx_tick) rx_tick_q <= rx_tick_q + 4'd1;
      if (!rxEn) begin
        rx_state_q <= StIdle;
        rx_tick_q  <= '0;
      end else begin
        unique case (rx_state_q)
          StIdle: begin
            rx_tick_q <= '0;
            // rx_prev_q must be high, so a low stop bit cannot re-arm until rx returns high
            if (rx_fall) rx_state_q <= StStart;
          end
          StStart: begin
            if (rx_tick && rx_tick_q == 4'd7) begin
              rx_tick_q <= '0;
              if (!rx_s2_q) begin
                rx_state_q <= StData;
                rx_bit_q   <= '0;
              end else begin
                rx_err_q   <= 1'b1;
                rx_state_q <= StIdle;
              end
            end
          end
          StData: begin
            if (rx_tick && rx_tick_q == 4'd15) begin
              rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
              rx_bit_q   <= rx_bit_q + 3'd1;
              if (rx_bit_q == 3'd7) rx_state_q <= StStop;
            end
          end
          StStop: begin
            if (rx_tick && rx_tick_q == 4'd15) begin
              if (rx_s2_q) begin
                out_q     <= rx_shift_q;
                rx_done_q <= 1'b1;
              end else begin
                rx_err_q  <= 1'b1;
              end
              rx_state_q <= StIdle;
            end
          end
          default: rx_state_q <= StIdle;
        endcase
      end
    end
  end

  assign rxBusy = (rx_state_q != StIdle);
  assign rxDone = rx_done_q;
  assign rxErr  = rx_err_q;
  assign out    = out_q;

  // Transmitter
  state_e            tx_state_q;
  logic [TxDivW-1:0] tx_div_q;
  logic [2:0]        tx_bit_q;
  logic [7:0]        tx_data_q;
  logic              tx_q, tx_done_q;
  logic              tx_end;

  assign tx_end = (tx_div_q == TxDivW'(TxDiv - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= StIdle;
      tx_div_q   <= '0;
      tx_bit_q   <= '0;
      tx_data_q  <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      tx_div_q  <= tx_end ? '0 : tx_div_q + 1'b1;
      if (!txEn) begin
        tx_state_q <= StIdle;
        tx_q       <= 1'b1;
        tx_div_q   <= '0;
      end else begin
        unique case (tx_state_q)
          StIdle: begin
            tx_div_q <= '0;
            if (txStart) begin
              tx_data_q  <= in;
              tx_q       <= 1'b0;
              tx_state_q <= StStart;
            end
          end
          StStart: begin
            if (tx_end) begin
              tx_q       <= tx_data_q[0];
              tx_data_q  <= {1'b0, tx_data_q[7:1]};
              tx_bit_q   <= '0;
              tx_state_q <= StData;
            end
          end
          StData: begin
            if (tx_end) begin
              if (tx_bit_q == 3'd7) begin
                tx_q       <= 1'b1;
                tx_state_q <= StStop;
              end else begin
                tx_q      <= tx_data_q[0];
                tx_data_q <= {1'b0, tx_data_q[7:1]};
                tx_bit_q  <= tx_bit_q + 3'd1;
              end
            end
          end
          StStop: begin
            if (tx_end) begin
              tx_done_q  <= 1'b1;
              tx_state_q <= StIdle;
            end
          end
          default: tx_state_q <= StIdle;
        endcase
      end
    end
  end

  assign txBusy = (tx_state_q != StIdle);
  assign txDone = tx_done_q;
  assign tx     = tx_q;

endmodule

// File: tb/tb_uart8.sv
// Directed bench for uart8 at the 12 MHz / 9600 baud build (12 clocks per microsecond).
`timescale 1ns/1ps
module tb_uart8;

  logic       clk = 1'b0;
  logic       reset, rx_en, rx, tx_en, tx_start;
  logic [7:0] tx_byte;
  logic       rx_busy, rx_done, rx_err, tx_busy, tx_done, tx;
  logic [7:0] rx_byte;

  int n_vec = 0;
  int n_err = 0;
  int rx_done_n = 0, rx_err_n = 0, tx_done_n = 0, tx_busy_n = 0;

  uart8 #(.CLOCK_RATE(12000000), .BAUD_RATE(9600)) dut (
    .clk     (clk),
    .reset   (reset),
    .rxEn    (rx_en),
    .rx      (rx),
    .rxBusy  (rx_busy),
    .rxDone  (rx_done),
    .rxErr   (rx_err),
    .out     (rx_byte),
    .txEn    (tx_en),
    .txStart (tx_start),
    .in      (tx_byte),
    .txBusy  (tx_busy),
    .txDone  (tx_done),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  function automatic void check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endfunction

  // Pulse bookkeeping; deltas of these counters are checked by the main sequence.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_done) begin
        rx_done_n++;
        check("rxdone_busy_low", 32'(rx_busy), 32'd0);
        check("rxdone_no_err", 32'(rx_err), 32'd0);
      end
      if (rx_err) rx_err_n++;
      if (tx_done) begin
        tx_done_n++;
        check("txdone_busy_low", 32'(tx_busy), 32'd0);
      end
      if (tx_busy) tx_busy_n++;
    end
  end

  task automatic drive_rx(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input int bit_clks, input int start_clks,
                            input logic stop_val);
    drive_rx(1'b0, start_clks);
    for (int i = 0; i < 8; i++) drive_rx(data[i], bit_clks);
    drive_rx(stop_val, bit_clks);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_rxbusy"}, 32'(rx_busy), 32'd0);
    check({pfx, "_rxdone"}, 32'(rx_done), 32'd0);
    check({pfx, "_rxerr"}, 32'(rx_err), 32'd0);
    check({pfx, "_out"}, 32'(rx_byte), 32'h00);
    check({pfx, "_tx"}, 32'(tx), 32'd1);
    check({pfx, "_txbusy"}, 32'(tx_busy), 32'd0);
    check({pfx, "_txdone"}, 32'(tx_done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, t0, b0;
    logic [9:0] tx_exp;
    reset = 1'b1; rx_en = 1'b1; rx = 1'b1; tx_en = 1'b1; tx_start = 1'b0; tx_byte = 8'h00;
    #23;
    check_reset_values("init");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk); #1;

    // 16 us low glitch then 36 us high: false start
    d0 = rx_done_n; e0 = rx_err_n;
    drive_rx(1'b0, 192);
    drive_rx(1'b1, 432);
    drive_rx(1'b1, 200);
    check("glitch_err", 32'(rx_err_n - e0), 32'd1);
    check("glitch_done", 32'(rx_done_n - d0), 32'd0);
    check("glitch_busy", 32'(rx_busy), 32'd0);

    // 3% slow 8'hD6 frame on rx while tx sends 8'hD6
    d0 = rx_done_n; e0 = rx_err_n; t0 = tx_done_n; b0 = tx_busy_n;
    tx_exp = {1'b1, 8'hD6, 1'b0};
    fork
      begin
        send_frame(8'hD6, 1290, 1290, 1'b1);
        drive_rx(1'b1, 300);
      end
      begin
        tx_byte = 8'hD6; tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        check("tx_start_bit_now", 32'(tx), 32'd0);
        check("tx_busy_now", 32'(tx_busy), 32'd1);
        repeat (625) @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
          check($sformatf("tx_bit%0d", i), 32'(tx), 32'(tx_exp[i]));
          if (i < 9) begin
            repeat (1250) @(posedge clk); #1;
          end
        end
        repeat (1000) @(posedge clk); #1;
        check("tx_busy_cycles", 32'(tx_busy_n - b0), 32'd12500);
        check("tx_done_pulses", 32'(tx_done_n - t0), 32'd1);
        check("tx_idle_high", 32'(tx), 32'd1);
      end
    join
    check("slow_d6_done", 32'(rx_done_n - d0), 32'd1);
    check("slow_d6_err", 32'(rx_err_n - e0), 32'd0);
    check("slow_d6_out", 32'(rx_byte), 32'hD6);

    // Stop bit low: framing error, out keeps 8'hD6
    d0 = rx_done_n; e0 = rx_err_n;
    send_frame(8'h3A, 1250, 1250, 1'b0);
    drive_rx(1'b1, 1500);
    check("frm_err", 32'(rx_err_n - e0), 32'd1);
    check("frm_done", 32'(rx_done_n - d0), 32'd0);
    check("frm_out", 32'(rx_byte), 32'hD6);

    // Short (~53 us) start bit: out may only ever hold a stop-validated byte
    send_frame(8'hD6, 1250, 636, 1'b1);
    drive_rx(1'b1, 1500);
    check("short_out", 32'(rx_byte), 32'hD6);
    check("short_busy", 32'(rx_busy), 32'd0);

    // rxEn dropped mid-frame: frame discarded, no pulses
    d0 = rx_done_n; e0 = rx_err_n;
    fork
      send_frame(8'h3A, 1250, 1250, 1'b1);
      begin
        repeat (3000) @(posedge clk); #1;
        rx_en = 1'b0;
      end
    join
    check("rxen_busy", 32'(rx_busy), 32'd0);
    check("rxen_done", 32'(rx_done_n - d0), 32'd0);
    check("rxen_err", 32'(rx_err_n - e0), 32'd0);
    check("rxen_out", 32'(rx_byte), 32'hD6);
    rx_en = 1'b1;
    drive_rx(1'b1, 100);

    // Nominal 8'h3A frame
    d0 = rx_done_n; e0 = rx_err_n;
    send_frame(8'h3A, 1250, 1250, 1'b1);
    drive_rx(1'b1, 300);
    check("nom_3a_done", 32'(rx_done_n - d0), 32'd1);
    check("nom_3a_err", 32'(rx_err_n - e0), 32'd0);
    check("nom_3a_out", 32'(rx_byte), 32'h3A);

    // Asynchronous reset in the middle of both frames
    tx_byte = 8'hA5; tx_start = 1'b1; rx = 1'b0;
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (3000) @(posedge clk);
    #3;
    check("pre_rst_rxbusy", 32'(rx_busy), 32'd1);
    check("pre_rst_txbusy", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    rx = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
